// File: rtl/shift_pkg.sv
// Shared constants for the shift arbiter slice: data/count widths and opcodes.
package shift_pkg;

  localparam int unsigned SHW  = 16;
  localparam int unsigned CNTW = 4;

  localparam logic [1:0] OP_ROL = 2'b00;
  localparam logic [1:0] OP_SHL = 2'b01;
  localparam logic [1:0] OP_ROR = 2'b10;
  localparam logic [1:0] OP_SRL = 2'b11;

endpackage

// File: rtl/shift_arbiter_if.sv
// Request/response bundle between the two requesters and the shift arbiter.
interface shift_arbiter_if;
  import shift_pkg::*;

  logic                 req_valid_0;
  logic                 req_valid_1;
  logic                 req_ready_0;
  logic                 req_ready_1;
  logic [SHW-1:0]       req_in_0;
  logic [SHW-1:0]       req_in_1;
  logic [CNTW-1:0]      req_cnt_0;
  logic [CNTW-1:0]      req_cnt_1;
  logic [1:0]           req_op_0;
  logic [1:0]           req_op_1;
  logic                 resp_valid_0;
  logic                 resp_valid_1;
  logic                 resp_ready_0;
  logic                 resp_ready_1;
  logic [SHW-1:0]       resp_out;

  // Requester side
  modport master (
    output req_valid_0, req_valid_1, req_in_0, req_in_1,
           req_cnt_0, req_cnt_1, req_op_0, req_op_1,
           resp_ready_0, resp_ready_1,
    input  req_ready_0, req_ready_1, resp_valid_0, resp_valid_1, resp_out
  );

  // Arbiter side
  modport slave (
    input  req_valid_0, req_valid_1, req_in_0, req_in_1,
           req_cnt_0, req_cnt_1, req_op_0, req_op_1,
           resp_ready_0, resp_ready_1,
    output req_ready_0, req_ready_1, resp_valid_0, resp_valid_1, resp_out
  );

endinterface

// File: rtl/shift_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to prio.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       prio,
  output logic [1:0] gnt
);

  // One-hot-or-zero grant
  always_comb begin
    gnt    = '0;
    gnt[0] = req[0] & (~req[1] | ~prio);
    gnt[1] = req[1] & (~req[0] |  prio);
  end

endmodule

// File: rtl/shifter.sv
// 16-bit combinational barrel shifter: rotate/shift left/right by 0..15.
module shifter
  import shift_pkg::*;
(
  input  logic [SHW-1:0]  In,
  input  logic [CNTW-1:0] Cnt,
  input  logic [1:0]      Op,
  output logic [SHW-1:0]  Out
);

  logic [2*SHW-1:0] dbl;
  logic [2*SHW-1:0] dbl_l;
  logic [2*SHW-1:0] dbl_r;

  assign dbl   = {In, In};
  assign dbl_l = dbl << Cnt;
  assign dbl_r = dbl >> Cnt;

  // Rotates take the wrapped half of the doubled word; shifts zero-fill.
  always_comb begin
    Out = '0;
    unique case (Op)
      OP_ROL:  Out = dbl_l[2*SHW-1:SHW];
      OP_SHL:  Out = In << Cnt;
      OP_ROR:  Out = dbl_r[SHW-1:0];
      default: Out = In >> Cnt;
    endcase
  end

endmodule

// File: rtl/shift_arbiter.sv
// Shares one barrel shifter between two requesters; the registered result is
// returned only to the requester that issued it.
module shift_arbiter
  import shift_pkg::*;
#(
  parameter bit PRIO_RESET = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  shift_arbiter_if.slave bus
);

  logic            pend;
  logic            owner;
  logic            prio;
  logic [SHW-1:0]  res_q;

  logic [1:0]      gnt;
  logic            owner_ready;
  logic            resp_fire;
  logic            can_acc;
  logic            accept;
  logic [SHW-1:0]  sh_in;
  logic [CNTW-1:0] sh_cnt;
  logic [1:0]      sh_op;
  logic [SHW-1:0]  sh_out;

  rr_arb2 u_arb (
    .req  ({bus.req_valid_1, bus.req_valid_0}),
    .prio (prio),
    .gnt  (gnt)
  );

  shifter u_shifter (
    .In  (sh_in),
    .Cnt (sh_cnt),
    .Op  (sh_op),
    .Out (sh_out)
  );

  // Handshake decode; a draining owner frees the slot in the same cycle.
  always_comb begin
    owner_ready     = owner ? bus.resp_ready_1 : bus.resp_ready_0;
    resp_fire       = pend & owner_ready;
    can_acc         = ~pend | resp_fire;
    bus.req_ready_0 = can_acc & gnt[0];
    bus.req_ready_1 = can_acc & gnt[1];
    accept          = (bus.req_valid_0 & bus.req_ready_0) |
                      (bus.req_valid_1 & bus.req_ready_1);
  end

  // Steer the granted requester's operands into the shared shifter.
  always_comb begin
    sh_in  = bus.req_in_0;
    sh_cnt = bus.req_cnt_0;
    sh_op  = bus.req_op_0;
    if (gnt[1]) begin
      sh_in  = bus.req_in_1;
      sh_cnt = bus.req_cnt_1;
      sh_op  = bus.req_op_1;
    end
  end

  // Result slot and round-robin pointer; a new accept overrides a drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend  <= 1'b0;
      owner <= 1'b0;
      prio  <= PRIO_RESET;
      res_q <= '0;
    end else if (accept) begin
      pend  <= 1'b1;
      owner <= gnt[1];
      prio  <= ~gnt[1];
      res_q <= sh_out;
    end else if (resp_fire) begin
      pend  <= 1'b0;
    end
  end

  // Response outputs driven straight from state
  always_comb begin
    bus.resp_valid_0 = pend & ~owner;
    bus.resp_valid_1 = pend &  owner;
    bus.resp_out     = res_q;
  end

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: directed vector table, hand-written
// reset sequence, and a randomized run against a transaction-level model.
module tb_shift_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  shift_arbiter_if bus ();

  shift_arbiter #(.PRIO_RESET(1'b0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    bit          v0, v1;
    logic [15:0] in0, in1;
    logic [3:0]  c0, c1;
    logic [1:0]  o0, o1;
    bit          rr0, rr1;
    bit          e_r0, e_r1, e_v0, e_v1;
    logic [15:0] e_out;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit rst, bit v0, logic [15:0] in0, logic [3:0] c0, logic [1:0] o0,
                              bit v1, logic [15:0] in1, logic [3:0] c1, logic [1:0] o1,
                              bit rr0, bit rr1, bit e_r0, bit e_r1, bit e_v0, bit e_v1,
                              logic [15:0] e_out);
    vec_t v;
    v.rst = rst; v.v0 = v0; v.in0 = in0; v.c0 = c0; v.o0 = o0;
    v.v1 = v1; v.in1 = in1; v.c1 = c1; v.o1 = o1;
    v.rr0 = rr0; v.rr1 = rr1;
    v.e_r0 = e_r0; v.e_r1 = e_r1; v.e_v0 = e_v0; v.e_v1 = e_v1; v.e_out = e_out;
    return v;
  endfunction

  // Shift semantics from bit positions and arithmetic, not from the RTL structure.
  function automatic logic [15:0] ref_shift(logic [15:0] x, logic [3:0] c, logic [1:0] op);
    logic [15:0] r;
    int unsigned n;
    n = c;
    r = '0;
    case (op)
      2'b00: for (int j = 0; j < 16; j++) r[(j + n) % 16] = x[j];
      2'b01: r = 16'((32'(x) * (32'd1 << n)) % 32'd65536);
      2'b10: for (int j = 0; j < 16; j++) r[j] = x[(j + n) % 16];
      default: r = 16'(32'(x) / (32'd1 << n));
    endcase
    return r;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.req_valid_0  = v.v0;  bus.req_in_0 = v.in0; bus.req_cnt_0 = v.c0; bus.req_op_0 = v.o0;
    bus.req_valid_1  = v.v1;  bus.req_in_1 = v.in1; bus.req_cnt_1 = v.c1; bus.req_op_1 = v.o1;
    bus.resp_ready_0 = v.rr0; bus.resp_ready_1 = v.rr1;
  endtask

  task automatic idle_inputs();
    bus.req_valid_0 = 1'b0; bus.req_valid_1 = 1'b0;
    bus.req_in_0 = '0; bus.req_in_1 = '0;
    bus.req_cnt_0 = '0; bus.req_cnt_1 = '0;
    bus.req_op_0 = '0; bus.req_op_1 = '0;
    bus.resp_ready_0 = 1'b0; bus.resp_ready_1 = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Transaction-level model: one result slot (owner, value) and a preference.
  bit          m_busy;
  bit          m_who;
  bit          m_pref;
  logic [15:0] m_val;

  initial begin
    bit          hold0, hold1;
    bit          ex_r0, ex_r1, drained, win;
    logic [15:0] din [2];
    logic [15:0] x;

    idle_inputs();

    // Directed vector table (PRIO_RESET = 0)
    // Single ROL
    tbl.push_back(mk(1, 1,16'h8001,1,2'b00, 0,16'h0,0,2'b00, 1,0, 1,0,0,0, 16'h0000));
    tbl.push_back(mk(0, 0,16'h0,0,2'b00, 0,16'h0,0,2'b00, 1,1, 0,0,1,0, 16'h0003));
    // Tie alternation from reset
    tbl.push_back(mk(1, 1,16'hF000,4,2'b11, 1,16'h000F,4,2'b01, 1,1, 1,0,0,0, 16'h0000));
    tbl.push_back(mk(0, 1,16'hF000,4,2'b11, 1,16'h000F,4,2'b01, 1,1, 0,1,1,0, 16'h0F00));
    tbl.push_back(mk(0, 1,16'hF000,4,2'b11, 1,16'h000F,4,2'b01, 1,1, 1,0,0,1, 16'h00F0));
    tbl.push_back(mk(0, 1,16'hF000,4,2'b11, 1,16'h000F,4,2'b01, 1,1, 0,1,1,0, 16'h0F00));
    tbl.push_back(mk(0, 0,16'h0,0,2'b00, 0,16'h0,0,2'b00, 1,1, 0,0,0,1, 16'h00F0));
    // Back-pressure on requester 1
    tbl.push_back(mk(0, 0,16'h0,0,2'b00, 1,16'h0001,1,2'b10, 0,0, 0,1,0,0, 16'h00F0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0, 1,16'h1234,0,2'b00, 0,16'h0,0,2'b00, 0,0, 0,0,0,1, 16'h8000));
    tbl.push_back(mk(0, 1,16'h1234,0,2'b00, 0,16'h0,0,2'b00, 0,1, 1,0,0,1, 16'h8000));
    tbl.push_back(mk(0, 0,16'h0,0,2'b00, 0,16'h0,0,2'b00, 1,0, 0,0,1,0, 16'h1234));
    // Back-to-back, Cnt = 0, every opcode
    for (int i = 0; i < 8; i++) begin
      x = 16'hA5C3 ^ 16'(i * 16'h1111);
      tbl.push_back(mk(0, 1,x,0,2'(i % 4), 0,16'h0,0,2'b00, 1,0, 1,0, i > 0, 0,
                       (i > 0) ? (16'hA5C3 ^ 16'((i - 1) * 16'h1111)) : 16'h1234));
    end
    tbl.push_back(mk(0, 0,16'h0,0,2'b00, 0,16'h0,0,2'b00, 1,0, 0,0,1,0, 16'hA5C3 ^ 16'(7 * 16'h1111)));
    // Solo requester 1, then a tie goes to 0
    tbl.push_back(mk(1, 0,16'h0,0,2'b00, 1,16'h00FF,8,2'b00, 1,1, 0,1,0,0, 16'h0000));
    tbl.push_back(mk(0, 0,16'h0,0,2'b00, 1,16'h0F0F,4,2'b10, 1,1, 0,1,0,1, 16'hFF00));
    tbl.push_back(mk(0, 0,16'h0,0,2'b00, 1,16'h8000,15,2'b11, 1,1, 0,1,0,1, 16'hF0F0));
    tbl.push_back(mk(0, 1,16'h0003,2,2'b01, 1,16'hBEEF,3,2'b00, 1,1, 1,0,0,1, 16'h0001));
    tbl.push_back(mk(0, 0,16'h0,0,2'b00, 1,16'hBEEF,3,2'b00, 1,1, 0,1,1,0, 16'h000C));
    tbl.push_back(mk(0, 0,16'h0,0,2'b00, 0,16'h0,0,2'b00, 1,1, 0,0,0,1, 16'hF77D));

    foreach (tbl[k]) begin
      if (tbl[k].rst) begin
        do_reset();
        chk("reset_resp_valid", {14'b0, bus.resp_valid_1, bus.resp_valid_0}, 16'h0);
        chk("reset_resp_out", bus.resp_out, 16'h0000);
      end
      @(posedge clk); #1;
      drive(tbl[k]);
      @(negedge clk);
      chk($sformatf("vec%0d_req_ready_0", k), 16'(bus.req_ready_0), 16'(tbl[k].e_r0));
      chk($sformatf("vec%0d_req_ready_1", k), 16'(bus.req_ready_1), 16'(tbl[k].e_r1));
      chk($sformatf("vec%0d_resp_valid_0", k), 16'(bus.resp_valid_0), 16'(tbl[k].e_v0));
      chk($sformatf("vec%0d_resp_valid_1", k), 16'(bus.resp_valid_1), 16'(tbl[k].e_v1));
      chk($sformatf("vec%0d_resp_out", k), bus.resp_out, tbl[k].e_out);
    end

    // Asynchronous reset with a held result, then priority back to 0
    @(posedge clk); #1;
    idle_inputs();
    bus.req_valid_0 = 1'b1; bus.req_in_0 = 16'h00F0; bus.req_cnt_0 = 4'd4; bus.req_op_0 = 2'b01;
    @(negedge clk);
    chk("rst_seq_accept", 16'(bus.req_ready_0), 16'd1);
    @(posedge clk); #1;
    bus.req_valid_0 = 1'b0;
    @(negedge clk);
    chk("rst_seq_held", {bus.resp_valid_0, bus.resp_out[14:0]}, {1'b1, 15'h0F00});
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_resp_valid", {14'b0, bus.resp_valid_1, bus.resp_valid_0}, 16'h0);
    chk("rst_async_resp_out", bus.resp_out, 16'h0000);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    bus.req_valid_0 = 1'b1; bus.req_valid_1 = 1'b1;
    bus.resp_ready_0 = 1'b1; bus.resp_ready_1 = 1'b1;
    @(negedge clk);
    chk("rst_tie_ready", {14'b0, bus.req_ready_1, bus.req_ready_0}, 16'b01);

    // Randomized run against the transaction model
    do_reset();
    m_busy = 0; m_who = 0; m_pref = 0; m_val = '0;
    hold0 = 0; hold1 = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      if (!hold0) begin
        bus.req_valid_0 = ($urandom_range(0, 9) < 6);
        bus.req_in_0 = 16'($urandom); bus.req_cnt_0 = 4'($urandom); bus.req_op_0 = 2'($urandom);
        hold0 = bus.req_valid_0;
      end
      if (!hold1) begin
        bus.req_valid_1 = ($urandom_range(0, 9) < 6);
        bus.req_in_1 = 16'($urandom); bus.req_cnt_1 = 4'($urandom); bus.req_op_1 = 2'($urandom);
        hold1 = bus.req_valid_1;
      end
      bus.resp_ready_0 = ($urandom_range(0, 9) < 7);
      bus.resp_ready_1 = ($urandom_range(0, 9) < 7);
      @(negedge clk);

      drained = m_busy && (m_who ? bus.resp_ready_1 : bus.resp_ready_0);
      if (bus.req_valid_0 && bus.req_valid_1) win = m_pref;
      else win = bus.req_valid_1;
      ex_r0 = (!m_busy || drained) && bus.req_valid_0 && (win == 1'b0);
      ex_r1 = (!m_busy || drained) && bus.req_valid_1 && (win == 1'b1);

      chk("rand_req_ready", {14'b0, bus.req_ready_1, bus.req_ready_0}, {14'b0, ex_r1, ex_r0});
      chk("rand_resp_valid", {14'b0, bus.resp_valid_1, bus.resp_valid_0},
          {14'b0, m_busy && m_who, m_busy && !m_who});
      if (m_busy) chk("rand_resp_out", bus.resp_out, m_val);

      din[0] = ref_shift(bus.req_in_0, bus.req_cnt_0, bus.req_op_0);
      din[1] = ref_shift(bus.req_in_1, bus.req_cnt_1, bus.req_op_1);
      if (ex_r0 || ex_r1) begin
        m_busy = 1; m_who = ex_r1; m_val = din[ex_r1]; m_pref = !ex_r1;
        if (ex_r0) hold0 = 0;
        if (ex_r1) hold1 = 0;
      end else if (drained) begin
        m_busy = 0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

Round-robin arbiter that shares one instance of the 16-bit barrel shifter `shifter` between two requesters, e.g. the execute-stage ALU path and a multi-cycle multiply/divide helper. Each requester has a valid/ready request channel and a valid/ready response channel. The block registers the shifter result and returns it only to the requester that issued it. It sustains one shift per cycle when responses are drained promptly.

## Interface
- `PRIO_RESET`, default 0: requester that holds priority after reset (0 or 1).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid_0`, `req_valid_1` in 1: request present.
- `req_ready_0`, `req_ready_1` out 1: request accepted this cycle when high together with the matching valid.
- `req_in_0`, `req_in_1` in 16: operand.
- `req_cnt_0`, `req_cnt_1` in 4: shift amount, 0–15.
- `req_op_0`, `req_op_1` in 2: opcode. 00 rotate left, 01 shift left, 10 rotate right, 11 logical shift right.
- `resp_valid_0`, `resp_valid_1` out 1: result pending for that requester.
- `resp_ready_0`, `resp_ready_1` in 1: requester consumes the result.
- `resp_out` out 16: registered result. Shared by both responders and meaningful only with the `resp_valid_*` that is high.

## Operation
- State: `pend` (result held), `owner` (requester of the held result), `prio` (round-robin pointer), `res_q[15:0]`.
- `resp_fire = pend & resp_ready_owner`.
- `can_acc = ~pend | resp_fire`.
- Grant, computed combinationally:
  - One requester valid: it wins.
  - Both valid: `prio` wins.
  - Grant is computed regardless of `can_acc`.
- `req_ready_i = can_acc & grant_i`. At most one `req_ready` is high in any cycle. A non-granted requester sees ready low.
- The shifter is driven combinationally from the granted requester's `In`, `Cnt` and `Op`. With no grant, the inputs are don't-care.
- On accept (`req_valid_i & req_ready_i`):
  - `res_q` takes the shifter output.
  - `owner` takes i.
  - `pend` is set to 1.
  - `prio` takes ~i, so the loser of the next tie is whoever was just served.
- On `resp_fire` with no accept: `pend` is cleared to 0, and `res_q` and `owner` hold their values.
- With `resp_fire` and an accept in the same cycle, the accept wins: `pend` stays 1 and the new result and owner load.
- `resp_valid_i = pend & (owner == i)`.
- `resp_out = res_q`.
- Requester protocol obligations:
  - Once `req_valid` is raised, it and its payload stay stable until accepted.
  - A requester may hold `resp_ready` high continuously.
- `prio` changes only on accept. It never changes because a request was merely present.

## Timing
- Reset values (immediate on `rst_n` low, independent of `clk`):
  - `pend` = 0, `owner` = 0, `res_q` = 16'h0000, `prio` = `PRIO_RESET`.
  - All `resp_valid` = 0.
  - `req_ready` still follows the combinational grant with `pend` = 0, so during reset a valid request sees ready high. Requesters must ignore handshakes while `rst_n` is low.
- Latency: a request accepted at edge t shows `resp_valid` and `resp_out` after edge t, so the response is valid in cycle t+1.
- Throughput: one accept per cycle while the current owner holds `resp_ready` high.
- Back-pressure: while `pend` is set and the owner holds `resp_ready` low:
  - both `req_ready` are low;
  - `resp_out` and `resp_valid` are stable.
- Combinational paths: `resp_ready_*` → `req_ready_*`, and `req_*` → shifter → `res_q` D input. There is no path from `req_valid` to `resp_valid`.
- Reset mid-operation: a held result is discarded with no response, and requests are not replayed.

## Structure
- Shared package `shift_pkg`:
  - opcode constants `OP_ROL` = 2'b00, `OP_SHL` = 2'b01, `OP_ROR` = 2'b10, `OP_SRL` = 2'b11;
  - `SHW` = 16;
  - `CNTW` = 4.
- Sub-module `rr_arb2`: inputs `req[1:0]`, `prio`; output `gnt[1:0]`. Purely combinational and one-hot-or-zero.
- The top instantiates `rr_arb2` and the existing `shifter` unchanged. Holding state is plain flops with asynchronous clear.

## Test plan
- Single ROL: requester 0 sends In=16'h8001, Cnt=1, Op=00, and holds `resp_ready_0`=1. Required: ready in the same cycle, then next cycle `resp_valid_0`=1 with `resp_out`=16'h0003, and `resp_valid_1`=0.
- Tie alternation, `PRIO_RESET`=0: both requesters valid for 4 cycles, requester 0 with SRL 16'hF000 by 4 and requester 1 with SHL 16'h000F by 4, both resp_ready held high. Required grants 0,1,0,1 and responses 16'h0F00, 16'h00F0 alternating on the correct `resp_valid`.
- Back-pressure: requester 1 sends ROR 16'h0001 by 1 with `resp_ready_1`=0 for 3 cycles while requester 0 is valid. Required: `resp_out`=16'h8000 stable, both `req_ready` low; then `resp_ready_1`=1 makes `req_ready_0`=1 in the same cycle.
- Back-to-back: requester 0 issues 8 consecutive shifts with Cnt=0 and always-ready. Required: 8 accepts in 8 cycles, each `resp_out` equal to its `In` for all opcodes.
- Reset mid-operation: result pending with `resp_ready` low, then pulse `rst_n` low asynchronously mid-cycle. Required: `resp_valid_*`=0 and `resp_out`=0 immediately, and after release the first tie is granted to `PRIO_RESET`.
- Solo requester: requester 1 alone for 3 accepts. Required: all accepted, and a later tie goes to 0.
